alu_issue_stage: RTL and testbench
==================================

// Module: alu_issue_stage
// PURPOSE
//  ID/EX issue register that drives the ALU: decodes opcode/funct3/funct7[5] into the 4-bit
//  Operation code, selects SrcA/SrcB, and holds them in a single pipeline register.
//  Sits between decode and the ALU; valid/ready handshake upstream, stall/flush from hazard unit.
// PARAMETERS
//  DATA_WIDTH     32  operand width
//  OPCODE_LENGTH   4  width of Operation to ALU
//  SHAMT_W         5  shift-amount bits kept in SrcB for shift ops (= clog2(DATA_WIDTH))
// PORTS
//  clk           in   1           rising-edge clock
//  reset         in   1           synchronous, active-high reset
//  in_valid      in   1           decode presents an instruction
//  in_ready      out  1           stage accepts this cycle
//  opcode        in   7           instr[6:0]
//  funct3        in   3           instr[14:12]
//  funct7b5      in   1           instr[30]
//  rs1_data      in   DATA_WIDTH  register operand 1
//  rs2_data      in   DATA_WIDTH  register operand 2
//  imm           in   DATA_WIDTH  sign-extended immediate
//  pc            in   DATA_WIDTH  instruction PC
//  ex_ready      in   1           EX consumes the held entry (0 = stall)
//  flush         in   1           squash held entry and any incoming instruction
//  ex_valid      out  1           held entry is valid
//  SrcA          out  DATA_WIDTH  ALU operand A
//  SrcB          out  DATA_WIDTH  ALU operand B
//  Operation     out  OPCODE_LENGTH ALU operation
//  ex_illegal    out  1           held entry failed decode
//  illegal_count out  8           saturating count of accepted illegal instrs
// BEHAVIOUR
//  Reset: ex_valid=0, SrcA=0, SrcB=0, Operation=0000, ex_illegal=0, illegal_count=0.
//  in_ready = !ex_valid || ex_ready (combinational); accept = in_valid && in_ready.
//  Latency 1: accepted instr appears on outputs next cycle. Stall (ex_valid && !ex_ready):
//   all outputs hold bit-exact; no new accept.
//  Priority per edge: reset > flush > accept > hold. flush: ex_valid<=0, ex_illegal<=0,
//   incoming instr dropped (not counted); data regs may hold stale values.
//  Consumed without new accept: ex_valid<=0.
//  Codes: AND 0000 OR 0001 ADD 0010 SUB 0011 SLL 0100 SRL 0101 SRA 0111 EQ 1000 NE 1001
//   LT 1011 XOR 1101 JAL 1110 GE 1111.
//  0110011 (R): f3 000 ADD/SUB(b5) 001 SLL 010 LT 100 XOR 101 SRL/SRA(b5) 110 OR 111 AND;
//   A=rs1 B=rs2. 0010011 (I): same map but 000 always ADD; B=imm.
//  Shifts (R and I): B = zero-extended low SHAMT_W bits of rs2/imm.
//  0000011 load, 0100011 store: ADD, A=rs1 B=imm.
//  1100011 branch: f3 000 EQ 001 NE 100 LT 101 GE; A=rs1 B=rs2.
//  1101111 JAL, 1100111 JALR: JAL code, A=pc B=imm.
//  Anything else (incl. f3 011, branch f3 010/011/110/111): illegal -> Operation 0000, A=B=0,
//   ex_illegal=1, ex_valid=1; illegal_count+=1, saturates at 255.
//  flush and reset mid-stall: entry dropped next cycle, in_ready=1 after.
// TESTING
//  reset 2 cycles -> ex_valid=0, Operation=0000, SrcA=SrcB=0, illegal_count=0, in_ready=1.
//  R SUB rs1=10 rs2=3 -> next cycle ex_valid=1 Operation=0011 SrcA=10 SrcB=3.
//  I SRAI imm=0x0000_0403, rs1=0x8000_0000 -> Operation=0111 SrcB=3 (upper bits masked).
//  ex_ready=0 for 3 cycles with in_valid=1 -> outputs frozen, in_ready=0; ex_ready=1 ->
//   next instr loaded the following edge, none lost.
//  flush with held entry and in_valid=1 -> ex_valid=0 next cycle, illegal_count unchanged.
//  300 illegal opcodes (7'b1111111) back-to-back -> illegal_count=255, ex_illegal=1.

Source files
------------

// File: rtl/alu_issue_stage.sv
// ID/EX issue register feeding the ALU: decodes opcode/funct3/funct7[5] into an ALU
// operation, selects SrcA/SrcB, and holds the result in one pipeline register.
module alu_issue_stage #(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 4,
  parameter int SHAMT_W       = 5
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [6:0]               opcode,
  input  logic [2:0]               funct3,
  input  logic                     funct7b5,
  input  logic [DATA_WIDTH-1:0]    rs1_data,
  input  logic [DATA_WIDTH-1:0]    rs2_data,
  input  logic [DATA_WIDTH-1:0]    imm,
  input  logic [DATA_WIDTH-1:0]    pc,
  input  logic                     ex_ready,
  input  logic                     flush,
  output logic                     ex_valid,
  output logic [DATA_WIDTH-1:0]    SrcA,
  output logic [DATA_WIDTH-1:0]    SrcB,
  output logic [OPCODE_LENGTH-1:0] Operation,
  output logic                     ex_illegal,
  output logic [7:0]               illegal_count
);

  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_I      = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  localparam logic [OPCODE_LENGTH-1:0] OP_AND = OPCODE_LENGTH'(4'b0000);
  localparam logic [OPCODE_LENGTH-1:0] OP_OR  = OPCODE_LENGTH'(4'b0001);
  localparam logic [OPCODE_LENGTH-1:0] OP_ADD = OPCODE_LENGTH'(4'b0010);
  localparam logic [OPCODE_LENGTH-1:0] OP_SUB = OPCODE_LENGTH'(4'b0011);
  localparam logic [OPCODE_LENGTH-1:0] OP_SLL = OPCODE_LENGTH'(4'b0100);
  localparam logic [OPCODE_LENGTH-1:0] OP_SRL = OPCODE_LENGTH'(4'b0101);
  localparam logic [OPCODE_LENGTH-1:0] OP_SRA = OPCODE_LENGTH'(4'b0111);
  localparam logic [OPCODE_LENGTH-1:0] OP_EQ  = OPCODE_LENGTH'(4'b1000);
  localparam logic [OPCODE_LENGTH-1:0] OP_NE  = OPCODE_LENGTH'(4'b1001);
  localparam logic [OPCODE_LENGTH-1:0] OP_LT  = OPCODE_LENGTH'(4'b1011);
  localparam logic [OPCODE_LENGTH-1:0] OP_XOR = OPCODE_LENGTH'(4'b1101);
  localparam logic [OPCODE_LENGTH-1:0] OP_JAL = OPCODE_LENGTH'(4'b1110);
  localparam logic [OPCODE_LENGTH-1:0] OP_GE  = OPCODE_LENGTH'(4'b1111);

  logic                     ex_valid_q, ex_illegal_q;
  logic [DATA_WIDTH-1:0]    src_a_q, src_b_q;
  logic [OPCODE_LENGTH-1:0] op_q;
  logic [7:0]               illegal_count_q;

  logic                     dec_ill;
  logic [OPCODE_LENGTH-1:0] dec_op;
  logic [DATA_WIDTH-1:0]    dec_a, dec_b;
  logic [DATA_WIDTH-1:0]    alu_b_raw, alu_shamt;
  logic                     accept;

  // Handshake: upstream transfers when in_valid && in_ready; the held entry leaves
  // when ex_valid && ex_ready. A stalled entry never blocks its own consumption.
  assign in_ready = !ex_valid_q || ex_ready;
  assign accept   = in_valid && in_ready;

  assign alu_b_raw = (opcode == OPC_R) ? rs2_data : imm;
  assign alu_shamt = {{(DATA_WIDTH-SHAMT_W){1'b0}}, alu_b_raw[SHAMT_W-1:0]};

  always_comb begin
    dec_ill = 1'b0;
    dec_op  = OP_AND;
    dec_a   = '0;
    dec_b   = '0;
    case (opcode)
      OPC_R, OPC_I: begin
        dec_a = rs1_data;
        dec_b = alu_b_raw;
        case (funct3)
          3'b000: dec_op = (opcode == OPC_R && funct7b5) ? OP_SUB : OP_ADD;
          3'b001: begin dec_op = OP_SLL; dec_b = alu_shamt; end
          3'b010: dec_op = OP_LT;
          3'b100: dec_op = OP_XOR;
          3'b101: begin dec_op = funct7b5 ? OP_SRA : OP_SRL; dec_b = alu_shamt; end
          3'b110: dec_op = OP_OR;
          3'b111: dec_op = OP_AND;
          default: dec_ill = 1'b1;
        endcase
      end
      OPC_LOAD, OPC_STORE: begin
        dec_op = OP_ADD;
        dec_a  = rs1_data;
        dec_b  = imm;
      end
      OPC_BRANCH: begin
        dec_a = rs1_data;
        dec_b = rs2_data;
        case (funct3)
          3'b000:  dec_op = OP_EQ;
          3'b001:  dec_op = OP_NE;
          3'b100:  dec_op = OP_LT;
          3'b101:  dec_op = OP_GE;
          default: dec_ill = 1'b1;
        endcase
      end
      OPC_JAL, OPC_JALR: begin
        dec_op = OP_JAL;
        dec_a  = pc;
        dec_b  = imm;
      end
      default: dec_ill = 1'b1;
    endcase
    // Illegal entries present a clean all-zero operation to the ALU.
    if (dec_ill) begin
      dec_op = OP_AND;
      dec_a  = '0;
      dec_b  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ex_valid_q      <= 1'b0;
      ex_illegal_q    <= 1'b0;
      src_a_q         <= '0;
      src_b_q         <= '0;
      op_q            <= OP_AND;
      illegal_count_q <= 8'd0;
    end else if (flush) begin
      ex_valid_q   <= 1'b0;
      ex_illegal_q <= 1'b0;
    end else if (accept) begin
      ex_valid_q   <= 1'b1;
      ex_illegal_q <= dec_ill;
      src_a_q      <= dec_a;
      src_b_q      <= dec_b;
      op_q         <= dec_op;
      if (dec_ill && illegal_count_q != 8'hFF) illegal_count_q <= illegal_count_q + 8'd1;
    end else if (ex_ready) begin
      ex_valid_q <= 1'b0;
    end
  end

  assign ex_valid      = ex_valid_q;
  assign ex_illegal    = ex_illegal_q;
  assign SrcA          = src_a_q;
  assign SrcB          = src_b_q;
  assign Operation     = op_q;
  assign illegal_count = illegal_count_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: directed literal checks plus randomized traffic compared
// every cycle against a table-driven reference model with a one-deep expected queue.
module tb_alu_issue_stage;

  localparam int W  = 32;
  localparam int EW = 1 + 4 + W + W;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [6:0]    opcode = 7'd0;
  logic [2:0]    funct3 = 3'd0;
  logic          funct7b5 = 1'b0;
  logic [W-1:0]  rs1_data = '0, rs2_data = '0, imm = '0, pc = '0;
  logic          ex_ready = 1'b1;
  logic          flush = 1'b0;
  logic          ex_valid;
  logic [W-1:0]  SrcA, SrcB;
  logic [3:0]    Operation;
  logic          ex_illegal;
  logic [7:0]    illegal_count;

  int n_chk  = 0;
  int n_fail = 0;

  alu_issue_stage #(.DATA_WIDTH(W), .OPCODE_LENGTH(4), .SHAMT_W(5)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .funct3(funct3), .funct7b5(funct7b5),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .imm(imm), .pc(pc),
    .ex_ready(ex_ready), .flush(flush), .ex_valid(ex_valid),
    .SrcA(SrcA), .SrcB(SrcB), .Operation(Operation),
    .ex_illegal(ex_illegal), .illegal_count(illegal_count)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // reference model: lookup tables by funct3, -1 marks an illegal encoding
  int alu_tbl [8] = '{2, 4, 11, -1, 13, 5, 1, 0};
  int br_tbl  [8] = '{8, 9, -1, -1, 11, 15, -1, -1};

  function automatic logic [EW-1:0] ref_decode(input logic [6:0] opc, input logic [2:0] f3,
      input logic b5, input logic [W-1:0] r1, input logic [W-1:0] r2,
      input logic [W-1:0] im, input logic [W-1:0] pcv);
    bit ill = 0;
    int code = 0;
    logic [W-1:0] a = '0, b = '0;
    if (opc == 7'h33 || opc == 7'h13) begin
      code = alu_tbl[f3];
      if (code < 0) ill = 1;
      else begin
        a = r1;
        b = (opc == 7'h33) ? r2 : im;
        if (f3 == 3'd1 || f3 == 3'd5) b = b % 32;
        if (b5 && f3 == 3'd5) code = code + 2;
        if (b5 && f3 == 3'd0 && opc == 7'h33) code = code + 1;
      end
    end else if (opc == 7'h03 || opc == 7'h23) begin
      code = 2; a = r1; b = im;
    end else if (opc == 7'h63) begin
      code = br_tbl[f3];
      if (code < 0) ill = 1;
      else begin a = r1; b = r2; end
    end else if (opc == 7'h6F || opc == 7'h67) begin
      code = 14; a = pcv; b = im;
    end else ill = 1;
    if (ill) begin code = 0; a = '0; b = '0; end
    return {ill, 4'(code), a, b};
  endfunction

  // scoreboard: exp_q holds the entry the stage must be presenting
  logic [EW-1:0] exp_q[$];
  bit started    = 0;
  bit ill_zero   = 0;
  int m_cnt      = 0;

  always @(posedge clk) begin
    logic [EW-1:0] e;
    if (reset) begin
      exp_q.delete(); m_cnt = 0; ill_zero = 1; started = 1;
    end else if (flush) begin
      exp_q.delete(); ill_zero = 1;
    end else if (in_valid && (exp_q.size() == 0 || ex_ready)) begin
      e = ref_decode(opcode, funct3, funct7b5, rs1_data, rs2_data, imm, pc);
      exp_q.delete();
      exp_q.push_back(e);
      if (e[EW-1]) m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
      ill_zero = 0;
    end else if (ex_ready && exp_q.size() != 0) begin
      void'(exp_q.pop_front());
    end
  end

  // compare process
  always @(negedge clk) begin
    logic [EW-1:0] e;
    if (started) begin
      chk("ex_valid", 64'(ex_valid), 64'(exp_q.size() != 0));
      chk("in_ready", 64'(in_ready), 64'(exp_q.size() == 0 || ex_ready));
      chk("illegal_count", 64'(illegal_count), 64'(m_cnt));
      if (exp_q.size() != 0) begin
        e = exp_q[0];
        chk("ex_illegal", 64'(ex_illegal), 64'(e[EW-1]));
        chk("Operation", 64'(Operation), 64'(e[2*W+3:2*W]));
        chk("SrcA", 64'(SrcA), 64'(e[2*W-1:W]));
        chk("SrcB", 64'(SrcB), 64'(e[W-1:0]));
      end else if (ill_zero) begin
        chk("ex_illegal_cleared", 64'(ex_illegal), 64'd0);
      end
    end
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [6:0] opc, input logic [2:0] f3, input logic b5,
      input logic [W-1:0] r1, input logic [W-1:0] r2, input logic [W-1:0] im);
    in_valid = 1'b1; opcode = opc; funct3 = f3; funct7b5 = b5;
    rs1_data = r1; rs2_data = r2; imm = im; pc = $urandom;
  endtask

  int opc_tbl [10] = '{'h33, 'h13, 'h03, 'h23, 'h63, 'h6F, 'h67, 'h7F, 'h00, 'h37};

  initial begin
    reset = 1'b1;
    repeat (2) step();
    reset = 1'b0;
    chk("rst ex_valid", 64'(ex_valid), 64'd0);
    chk("rst Operation", 64'(Operation), 64'd0);
    chk("rst SrcA", 64'(SrcA), 64'd0);
    chk("rst SrcB", 64'(SrcB), 64'd0);
    chk("rst illegal_count", 64'(illegal_count), 64'd0);
    chk("rst in_ready", 64'(in_ready), 64'd1);

    drive(7'b0110011, 3'b000, 1'b1, 32'd10, 32'd3, 32'd0);
    step();
    chk("sub ex_valid", 64'(ex_valid), 64'd1);
    chk("sub Operation", 64'(Operation), 64'h3);
    chk("sub SrcA", 64'(SrcA), 64'd10);
    chk("sub SrcB", 64'(SrcB), 64'd3);

    drive(7'b0010011, 3'b101, 1'b1, 32'h8000_0000, 32'h0, 32'h0000_0403);
    step();
    chk("srai Operation", 64'(Operation), 64'h7);
    chk("srai SrcB", 64'(SrcB), 64'd3);
    chk("srai SrcA", 64'(SrcA), 64'h8000_0000);

    ex_ready = 1'b0;
    drive(7'b0110011, 3'b000, 1'b0, 32'd5, 32'd7, 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall in_ready", 64'(in_ready), 64'd0);
      chk("stall Operation", 64'(Operation), 64'h7);
      chk("stall SrcB", 64'(SrcB), 64'd3);
    end
    ex_ready = 1'b1;
    #1;
    chk("unstall in_ready", 64'(in_ready), 64'd1);
    step();
    chk("after stall Operation", 64'(Operation), 64'h2);
    chk("after stall SrcA", 64'(SrcA), 64'd5);
    chk("after stall SrcB", 64'(SrcB), 64'd7);

    ex_ready = 1'b0;
    flush = 1'b1;
    drive(7'b1111111, 3'b000, 1'b0, 32'd1, 32'd2, 32'd3);
    step();
    flush = 1'b0;
    chk("flush ex_valid", 64'(ex_valid), 64'd0);
    chk("flush illegal_count", 64'(illegal_count), 64'd0);
    chk("flush in_ready", 64'(in_ready), 64'd1);

    ex_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      drive(7'b1111111, 3'($urandom), 1'($urandom), $urandom, $urandom, $urandom);
      step();
    end
    chk("sat illegal_count", 64'(illegal_count), 64'd255);
    chk("sat ex_illegal", 64'(ex_illegal), 64'd1);
    chk("sat Operation", 64'(Operation), 64'd0);
    chk("sat SrcA", 64'(SrcA), 64'd0);

    ex_ready = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("stall reset ex_valid", 64'(ex_valid), 64'd0);
    chk("stall reset illegal_count", 64'(illegal_count), 64'd0);
    chk("stall reset in_ready", 64'(in_ready), 64'd1);

    for (int i = 0; i < 3000; i++) begin
      drive(7'(opc_tbl[$urandom_range(0, 9)]), 3'($urandom), 1'($urandom),
            $urandom, $urandom, $urandom);
      in_valid = ($urandom_range(0, 3) != 0);
      ex_ready = ($urandom_range(0, 9) < 7);
      flush    = ($urandom_range(0, 19) == 0);
      reset    = ($urandom_range(0, 199) == 0);
      step();
    end
    in_valid = 1'b0; flush = 1'b0; reset = 1'b0;
    repeat (2) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
